// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the RAM-side signals of the data-memory arbiter.
// slave is the arbiter's view; master is the view of the requesters and the RAM.
interface dmem_arbiter_if;
  logic        m0_req, m1_req;
  logic        m0_we, m1_we;
  logic [2:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt;
  logic        m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_err, m1_err;
  logic        MemRead, MemWrite;
  logic [2:0]  MemSize;
  logic [31:0] A_Ram;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        busy;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_size, m1_size,
    input  m0_addr, m1_addr, m0_wdata, m1_wdata, ReadData,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
    output m0_err, m1_err, MemRead, MemWrite, MemSize, A_Ram, WriteData, busy
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_size, m1_size,
    output m0_addr, m1_addr, m0_wdata, m1_wdata, ReadData,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
    input  m0_err, m1_err, MemRead, MemWrite, MemSize, A_Ram, WriteData, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and IDLE->ACCESS->WAIT sequencer for the single-port data RAM.
// Size/alignment/range legality is decided when the command is latched; illegal accesses never strobe the RAM.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 32004
) (
  input  logic            clk,
  input  logic            resetn,
  dmem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic        last_grant_reg, owner_reg, we_reg, err_q_reg;
  logic        mem_read_reg, mem_write_reg;
  logic [2:0]  mem_size_reg;
  logic [31:0] a_ram_reg, write_data_reg;
  logic [1:0]  req, gnt;
  logic        grant_any, winner;
  logic        sel_we;
  logic [2:0]  sel_size;
  logic [31:0] sel_addr, sel_wdata;
  logic [2:0]  size_bytes;
  logic        size_ok, align_ok, range_ok, sel_err;
  logic [1:0]  rvalid_reg, err_reg;
  logic [31:0] rdata_reg [2];

  assign req = {bus.m1_req, bus.m0_req};

  // On a tie the port that did not win last time gets the RAM.
  always_comb begin
    state_next = state_reg;
    grant_any  = 1'b0;
    winner     = 1'b0;
    gnt        = 2'b00;
    case (state_reg)
      IDLE: begin
        if (resetn && (req != 2'b00)) begin
          grant_any  = 1'b1;
          winner     = req[1] & (~req[0] | ~last_grant_reg);
          gnt        = winner ? 2'b10 : 2'b01;
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = WAIT;
      WAIT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign sel_we    = winner ? bus.m1_we    : bus.m0_we;
  assign sel_size  = winner ? bus.m1_size  : bus.m0_size;
  assign sel_addr  = winner ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = winner ? bus.m1_wdata : bus.m0_wdata;

  // Halfwords are only accepted with addr[1] clear.
  always_comb begin
    size_bytes = 3'd0;
    size_ok    = 1'b1;
    align_ok   = 1'b1;
    case (sel_size)
      3'b000: size_bytes = 3'd1;
      3'b001: begin
        size_bytes = 3'd2;
        align_ok   = ~sel_addr[1];
      end
      3'b010: begin
        size_bytes = 3'd4;
        align_ok   = (sel_addr[1:0] == 2'b00);
      end
      default: size_ok = 1'b0;
    endcase
  end

  assign range_ok = ({1'b0, sel_addr} + {30'd0, size_bytes}) <= 33'(MEM_BYTES);
  assign sel_err  = ~(size_ok & align_ok & range_ok);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      we_reg         <= 1'b0;
      err_q_reg      <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_size_reg   <= 3'd0;
      a_ram_reg      <= 32'd0;
      write_data_reg <= 32'd0;
    end else begin
      state_reg     <= state_next;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      if (grant_any) begin
        last_grant_reg <= winner;
        owner_reg      <= winner;
        we_reg         <= sel_we;
        err_q_reg      <= sel_err;
        mem_size_reg   <= sel_size;
        a_ram_reg      <= sel_addr;
        write_data_reg <= sel_wdata;
        mem_read_reg   <= ~sel_we & ~sel_err;
        mem_write_reg  <= sel_we & ~sel_err;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          rvalid_reg[gi] <= 1'b0;
          err_reg[gi]    <= 1'b0;
          rdata_reg[gi]  <= 32'd0;
        end else begin
          rvalid_reg[gi] <= 1'b0;
          if ((state_reg == WAIT) && (owner_reg == 1'(gi))) begin
            rvalid_reg[gi] <= 1'b1;
            err_reg[gi]    <= err_q_reg;
            rdata_reg[gi]  <= (we_reg | err_q_reg) ? 32'd0 : bus.ReadData;
          end
        end
      end
    end
  endgenerate

  assign bus.m0_gnt    = gnt[0];
  assign bus.m1_gnt    = gnt[1];
  assign bus.m0_rvalid = rvalid_reg[0];
  assign bus.m1_rvalid = rvalid_reg[1];
  assign bus.m0_rdata  = rdata_reg[0];
  assign bus.m1_rdata  = rdata_reg[1];
  assign bus.m0_err    = err_reg[0];
  assign bus.m1_err    = err_reg[1];
  assign bus.MemRead   = mem_read_reg;
  assign bus.MemWrite  = mem_write_reg;
  assign bus.MemSize   = mem_size_reg;
  assign bus.A_Ram     = a_ram_reg;
  assign bus.WriteData = write_data_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: table of single-port transactions against a byte RAM model,
// plus round-robin, reset-in-flight and reset-value sequences.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.MEM_BYTES(32004)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Little-endian byte RAM with registered read.
  logic [7:0]  mem [0:32767];
  logic [14:0] ram_a;
  assign ram_a = bus.A_Ram[14:0];

  always @(posedge clk) begin
    if (bus.MemWrite) begin
      mem[ram_a] <= bus.WriteData[7:0];
      if (bus.MemSize != 3'b000) mem[ram_a + 15'd1] <= bus.WriteData[15:8];
      if (bus.MemSize == 3'b010) begin
        mem[ram_a + 15'd2] <= bus.WriteData[23:16];
        mem[ram_a + 15'd3] <= bus.WriteData[31:24];
      end
    end
    if (bus.MemRead) begin
      case (bus.MemSize)
        3'b000:  bus.ReadData <= {24'd0, mem[ram_a]};
        3'b001:  bus.ReadData <= {16'd0, mem[ram_a + 15'd1], mem[ram_a]};
        default: bus.ReadData <= {mem[ram_a + 15'd3], mem[ram_a + 15'd2],
                                  mem[ram_a + 15'd1], mem[ram_a]};
      endcase
    end
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_cmd(input logic port, input logic req, input logic we,
                         input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_size = size;
      bus.m1_addr = addr; bus.m1_wdata = wdata;
    end else begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_size = size;
      bus.m0_addr = addr; bus.m0_wdata = wdata;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " gnt"},    32'({bus.m0_gnt, bus.m1_gnt}), 32'd0);
    chk({tag, " strobe"}, 32'({bus.MemRead, bus.MemWrite}), 32'd0);
    chk({tag, " MemSize"}, 32'(bus.MemSize), 32'd0);
    chk({tag, " A_Ram"},  bus.A_Ram, 32'd0);
    chk({tag, " WriteData"}, bus.WriteData, 32'd0);
    chk({tag, " rvalid"}, 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'd0);
    chk({tag, " err"},    32'({bus.m0_err, bus.m1_err}), 32'd0);
    chk({tag, " m0_rdata"}, bus.m0_rdata, 32'd0);
    chk({tag, " m1_rdata"}, bus.m1_rdata, 32'd0);
    chk({tag, " busy"},   32'(bus.busy), 32'd0);
  endtask

  // One transaction on one port; checks grant, strobe cycle, wait cycle and response at gnt+3.
  task automatic run_txn(input int idx, input vec_t v);
    int   waitc;
    logic g, og, rv, orv, er;
    logic [31:0] rd;
    logic exp_rd, exp_wr;
    exp_rd = ~v.we & ~v.exp_err;
    exp_wr = v.we & ~v.exp_err;
    @(negedge clk);
    set_cmd(v.port, 1'b1, v.we, v.size, v.addr, v.wdata);
    #1;
    waitc = 0;
    g = v.port ? bus.m1_gnt : bus.m0_gnt;
    while (!g && waitc < 10) begin
      @(negedge clk); #1;
      waitc++;
      g = v.port ? bus.m1_gnt : bus.m0_gnt;
    end
    og = v.port ? bus.m0_gnt : bus.m1_gnt;
    chk($sformatf("txn%0d gnt", idx), 32'(g), 32'd1);
    chk($sformatf("txn%0d other gnt", idx), 32'(og), 32'd0);
    @(negedge clk);
    set_cmd(v.port, 1'b0, v.we, v.size, v.addr, v.wdata);
    chk($sformatf("txn%0d access MemRead", idx), 32'(bus.MemRead), 32'(exp_rd));
    chk($sformatf("txn%0d access MemWrite", idx), 32'(bus.MemWrite), 32'(exp_wr));
    chk($sformatf("txn%0d access busy", idx), 32'(bus.busy), 32'd1);
    if (!v.exp_err) chk($sformatf("txn%0d A_Ram", idx), bus.A_Ram, v.addr);
    @(negedge clk);
    chk($sformatf("txn%0d wait strobes", idx), 32'({bus.MemRead, bus.MemWrite}), 32'd0);
    chk($sformatf("txn%0d early rvalid", idx), 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'd0);
    @(negedge clk);
    rv  = v.port ? bus.m1_rvalid : bus.m0_rvalid;
    orv = v.port ? bus.m0_rvalid : bus.m1_rvalid;
    rd  = v.port ? bus.m1_rdata  : bus.m0_rdata;
    er  = v.port ? bus.m1_err    : bus.m0_err;
    chk($sformatf("txn%0d rvalid", idx), 32'(rv), 32'd1);
    chk($sformatf("txn%0d other rvalid", idx), 32'(orv), 32'd0);
    chk($sformatf("txn%0d rdata", idx), rd, v.exp_rdata);
    chk($sformatf("txn%0d err", idx), 32'(er), 32'(v.exp_err));
    chk($sformatf("txn%0d busy after", idx), 32'(bus.busy), 32'd0);
    $display("txn %0d port %0d we %0d size %0d addr %h -> rdata %h err %0d",
             idx, v.port, v.we, v.size, v.addr, rd, er);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
    bus.ReadData = 32'd0;
    set_cmd(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_cmd(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

    //            port  we    size    addr        wdata         exp_rdata     err
    vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h100,  32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 1'b0, 3'b010, 32'h100,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 3'b000, 32'h103,  32'h000000AB, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 1'b0, 3'b010, 32'h100,  32'h0,        32'hABADBEEF, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 3'b001, 32'h200,  32'h00001234, 32'h0,        1'b0};
    vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h200,  32'h0,        32'h00001234, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'b010, 32'h102,  32'h0,        32'h0,        1'b1};
    vecs[7]  = '{1'b0, 1'b0, 3'b001, 32'h2,    32'h0,        32'h0,        1'b1};
    vecs[8]  = '{1'b0, 1'b0, 3'b011, 32'h0,    32'h0,        32'h0,        1'b1};
    vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h7D04, 32'h0,        32'h0,        1'b1};
    vecs[10] = '{1'b1, 1'b1, 3'b010, 32'h7D00, 32'hCAFEF00D, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 1'b0, 3'b010, 32'h7D00, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 3'b000, 32'h7D03, 32'h0,        32'h000000CA, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 3'b000, 32'h7D04, 32'h0,        32'h0,        1'b1};
    vecs[14] = '{1'b0, 1'b1, 3'b010, 32'h101,  32'h11111111, 32'h0,        1'b1};

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    resetn = 1'b1;

    for (int i = 0; i < 15; i++) run_txn(i, vecs[i]);

    // Round-robin under continuous requests from both ports, starting from reset.
    begin
      int   ng, nrv, last_c;
      logic drop;
      ng = 0; nrv = 0; last_c = 0; drop = 1'b0;
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      set_cmd(1'b0, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
      set_cmd(1'b1, 1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
      #1;
      for (int c = 0; c < 40 && nrv < 6; c++) begin
        if (c > 0) begin
          @(negedge clk);
          if (drop) begin
            bus.m0_req = 1'b0;
            bus.m1_req = 1'b0;
          end
          #1;
        end
        chk("rr double gnt", 32'(bus.m0_gnt & bus.m1_gnt), 32'd0);
        chk("rr double rvalid", 32'(bus.m0_rvalid & bus.m1_rvalid), 32'd0);
        if (bus.m0_gnt | bus.m1_gnt) begin
          chk($sformatf("rr grant %0d port", ng), 32'(bus.m1_gnt), 32'(ng % 2));
          if (ng > 0) chk($sformatf("rr grant %0d gap", ng), 32'(c - last_c), 32'd3);
          $display("rr grant %0d to port %0d at cycle %0d", ng, bus.m1_gnt, c);
          last_c = c;
          ng++;
          if (ng == 6) drop = 1'b1;
        end
        nrv += int'(bus.m0_rvalid) + int'(bus.m1_rvalid);
      end
      chk("rr grant count", 32'(ng), 32'd6);
      chk("rr rvalid count", 32'(nrv), 32'd6);
    end

    // Reset during ACCESS of a port 1 read: outputs clear at once and no response follows.
    @(negedge clk);
    set_cmd(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    #1;
    chk("rst m1_gnt", 32'(bus.m1_gnt), 32'd1);
    @(negedge clk);
    bus.m1_req = 1'b0;
    chk("rst access MemRead", 32'(bus.MemRead), 32'd1);
    #1;
    resetn = 1'b0;
    set_cmd(1'b0, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    #1;
    check_all_zero("rst mid");
    @(negedge clk);
    bus.m0_req = 1'b0;
    resetn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rst no m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
      chk("rst idle busy", 32'(bus.busy), 32'd0);
    end
    $display("reset during access: port 1 read dropped");
    run_txn(15, '{1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 32'hABADBEEF, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
